// File: rtl/calc_display_ctrl_if.sv
// Board-side bundle for the switch calculator: raw buttons and switches in,
// status LEDs and the multiplexed seven-segment drive out.
interface calc_display_ctrl_if #(
   parameter int WIDTH = 8
);
   localparam int DIGITS = (WIDTH + 3) / 4;

   logic              BTN_STORE;
   logic              BTN_ADD;
   logic              BTN_SUB;
   logic              BTN_LIVE;
   logic [WIDTH-1:0]  sw;
   logic [4:0]        led;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;

   // Board / stimulus side
   modport master (
      output BTN_STORE, BTN_ADD, BTN_SUB, BTN_LIVE, sw,
      input  led, seg, an
   );

   // Controller side
   modport slave (
      input  BTN_STORE, BTN_ADD, BTN_SUB, BTN_LIVE, sw,
      output led, seg, an
   );
endinterface

// File: rtl/calc_display_ctrl.sv
// Switch-calculator front end: button synchronise/debounce, operand register
// with live/stored/sum/difference modes, and an N-digit multiplexed hex display.
module calc_display_ctrl #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int REFRESH_DIV     = 4096
) (
   input  logic               CLK,
   input  logic               RST,
   calc_display_ctrl_if.slave bus
);
   localparam int DIGITS = (WIDTH + 3) / 4;
   localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int NB     = 4;

   // Button bit positions inside the conditioned vectors
   localparam int B_LIVE  = 0;
   localparam int B_ADD   = 1;
   localparam int B_SUB   = 2;
   localparam int B_STORE = 3;

   typedef enum logic [1:0] {
      MODE_LIVE   = 2'd0,
      MODE_STORED = 2'd1,
      MODE_SUM    = 2'd2,
      MODE_DIFF   = 2'd3
   } mode_t;

   // ------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] sync1_q, sync2_q;
   logic [NB-1:0] level_vec;
   logic [NB-1:0] level_prev_q;
   logic [NB-1:0] press;

   assign btn_raw = {bus.BTN_STORE, bus.BTN_SUB, bus.BTN_ADD, bus.BTN_LIVE};

   // Two-flop synchroniser for every raw button
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_db
         logic [DB_W-1:0] cnt_q, cnt_d;
         logic            level_q, level_d;

         // Count consecutive disagreeing cycles; flip accepted level at the limit
         always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            if (sync2_q[gi] == level_q) begin
               cnt_d = '0;
            end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               level_d = ~level_q;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + DB_W'(1);
            end
         end

         // Debounce state register
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               cnt_q   <= '0;
               level_q <= 1'b0;
            end else begin
               cnt_q   <= cnt_d;
               level_q <= level_d;
            end
         end

         assign level_vec[gi] = level_q;
         assign press[gi]     = level_q & ~level_prev_q[gi];
      end
   endgenerate

   // Previous accepted levels, so a rising edge gives exactly one pulse
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) level_prev_q <= '0;
      else     level_prev_q <= level_vec;
   end

   // ------------------------------------------------------------------
   // Arithmetic on live switches and stored operand
   // ------------------------------------------------------------------
   mode_t            mode_q, mode_d;
   logic [WIDTH-1:0] stored_q, stored_d;
   logic [WIDTH:0]   sum_full;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   assign sum_full = {1'b0, bus.sw} + {1'b0, stored_q};
   assign diff     = bus.sw - stored_q;
   assign borrow   = (bus.sw < stored_q);

   // Mode / operand state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mode_q   <= MODE_LIVE;
         stored_q <= '0;
      end else begin
         mode_q   <= mode_d;
         stored_q <= stored_d;
      end
   end

   // Next state: one press acted on per cycle, STORE > SUB > ADD > LIVE
   always_comb begin
      mode_d   = mode_q;
      stored_d = stored_q;
      if (press[B_STORE]) begin
         stored_d = bus.sw;
         mode_d   = MODE_STORED;
      end else if (press[B_SUB]) begin
         if (mode_q == MODE_DIFF) stored_d = diff;
         mode_d = MODE_DIFF;
      end else if (press[B_ADD]) begin
         if (mode_q == MODE_SUM) stored_d = sum_full[WIDTH-1:0];
         mode_d = MODE_SUM;
      end else if (press[B_LIVE]) begin
         mode_d = MODE_LIVE;
      end
   end

   // Outputs: displayed value and status LEDs
   logic [WIDTH-1:0] disp_val;
   logic [4:0]       led_d;
   always_comb begin
      disp_val = bus.sw;
      case (mode_q)
         MODE_LIVE:   disp_val = bus.sw;
         MODE_STORED: disp_val = stored_q;
         MODE_SUM:    disp_val = sum_full[WIDTH-1:0];
         MODE_DIFF:   disp_val = diff;
         default:     disp_val = bus.sw;
      endcase
      led_d = {mode_q, (disp_val == '0), borrow, sum_full[WIDTH]};
   end

   assign bus.led = led_d;

   // ------------------------------------------------------------------
   // Display scan
   // ------------------------------------------------------------------
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   logic [RF_W-1:0]     refresh_q;
   logic [IDX_W-1:0]    idx_q;
   logic [6:0]          seg_q;
   logic [DIGITS-1:0]   an_q;
   logic [DIGITS*4-1:0] disp_pad;
   logic [3:0]          nibble;
   logic [DIGITS-1:0]   an_d;

   // Zero-pad the value to whole digits and pick the current nibble
   always_comb begin
      disp_pad              = '0;
      disp_pad[WIDTH-1:0]   = disp_val;
      nibble                = disp_pad[idx_q*4 +: 4];
      an_d                  = '0;
      an_d[idx_q]           = 1'b1;
   end

   // Refresh divider, digit index and registered segment/anode drive
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         refresh_q <= '0;
         idx_q     <= '0;
         seg_q     <= '0;
         an_q      <= '0;
      end else begin
         seg_q <= hex7(nibble);
         an_q  <= an_d;
         if (refresh_q == RF_W'(REFRESH_DIV - 1)) begin
            refresh_q <= '0;
            if (idx_q == IDX_W'(DIGITS - 1)) idx_q <= '0;
            else                             idx_q <= idx_q + IDX_W'(1);
         end else begin
            refresh_q <= refresh_q + RF_W'(1);
         end
      end
   end

   assign bus.seg = seg_q;
   assign bus.an  = an_q;
endmodule
